// File: rtl/echo_rank_ctrl.sv
// Multi-echo TDC window controller: opens a window on start, captures up to three hits,
// ranks them by intensity (descending, ties by arrival) and streams them strongest-first.
module echo_rank_ctrl #(
    parameter int TS_W    = 15,
    parameter int INT_W   = 5,
    parameter int WIN_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hit_vld,
    input  logic [TS_W-1:0]  hit_ts,
    input  logic [INT_W-1:0] hit_int,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [TS_W-1:0]  out_ts,
    output logic [INT_W-1:0] out_int,
    output logic [1:0]       out_rank,
    output logic             out_last,
    output logic [1:0]       hit_cnt,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_SORT    = 3'd2,
        S_OUTPUT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           win_cnt_q, win_cnt_d;
    logic [2:0][TS_W-1:0]       ts_q, ts_d;
    logic [2:0][INT_W-1:0]      int_q, int_d;
    logic [1:0]                 hit_cnt_q, hit_cnt_d;
    logic                       ovf_q, ovf_d;
    logic [2:0][1:0]            order_q, order_d;
    logic [1:0]                 beat_q, beat_d;
    logic [1:0]                 last_beat;
    logic [1:0]                 sel;

    assign last_beat = hit_cnt_q - 2'd1;

    // Position of slot i in the strongest-first order: count the valid slots that beat it.
    function automatic logic [1:0] rank_of(input int i, input logic [1:0] n,
                                           input logic [2:0][INT_W-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int j = 0; j < 3; j++) begin
            if (j != i && j < int'(n) && (v[j] > v[i] || (v[j] == v[i] && j < i)))
                r = r + 2'd1;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COLLECT;
            S_COLLECT: if (win_cnt_q == LAST_CNT) state_d = S_SORT;
            S_SORT:    state_d = (hit_cnt_q == 2'd0) ? S_DONE : S_OUTPUT;
            S_OUTPUT:  if (out_rdy && beat_q == last_beat) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        win_cnt_d = win_cnt_q;
        ts_d      = ts_q;
        int_d     = int_q;
        hit_cnt_d = hit_cnt_q;
        ovf_d     = ovf_q;
        order_d   = order_q;
        beat_d    = beat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    win_cnt_d = '0;
                    ts_d      = '0;
                    int_d     = '0;
                    hit_cnt_d = 2'd0;
                    ovf_d     = 1'b0;
                    beat_d    = 2'd0;
                end
            end
            S_COLLECT: begin
                // Hold at the final count so the counter never wraps inside a window.
                if (win_cnt_q != LAST_CNT) win_cnt_d = win_cnt_q + CNT_W'(1);
                if (hit_vld) begin
                    if (hit_cnt_q == 2'd3) begin
                        ovf_d = 1'b1;
                    end else begin
                        ts_d[hit_cnt_q]  = hit_ts;
                        int_d[hit_cnt_q] = hit_int;
                        hit_cnt_d        = hit_cnt_q + 2'd1;
                    end
                end
            end
            S_SORT: begin
                beat_d = 2'd0;
                for (int i = 0; i < 3; i++) begin
                    if (i < int'(hit_cnt_q)) order_d[rank_of(i, hit_cnt_q, int_q)] = 2'(i);
                end
            end
            S_OUTPUT: begin
                if (out_rdy && beat_q != last_beat) beat_d = beat_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
            ts_q      <= '0;
            int_q     <= '0;
            hit_cnt_q <= 2'd0;
            ovf_q     <= 1'b0;
            order_q   <= '0;
            beat_q    <= 2'd0;
        end else begin
            win_cnt_q <= win_cnt_d;
            ts_q      <= ts_d;
            int_q     <= int_d;
            hit_cnt_q <= hit_cnt_d;
            ovf_q     <= ovf_d;
            order_q   <= order_d;
            beat_q    <= beat_d;
        end
    end

    // Beat fields are forced to zero outside OUTPUT so nothing stale leaks downstream.
    always_comb begin
        out_vld  = (state_q == S_OUTPUT);
        sel      = order_q[beat_q];
        out_ts   = '0;
        out_int  = '0;
        out_rank = 2'd0;
        out_last = 1'b0;
        if (out_vld) begin
            out_ts   = ts_q[sel];
            out_int  = int_q[sel];
            out_rank = beat_q;
            out_last = (beat_q == last_beat);
        end
        hit_cnt  = hit_cnt_q;
        overflow = ovf_q;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end
endmodule
